diffusion_session_ctrl: RTL

// Sequences one diffusion session around the dual score-table / subgraph BRAMs.
// - LOAD: streams PS words into score_1, score_2, subgraph_1, subgraph_2, in that order.
// - RUN: hands the BRAMs to top_dual by raising diff_en (its rdy_flag / clock-gate mask).
// - READ: when done or timed out, streams score_1 then score_2 back to the PS.

---
 rtl/diffusion_session_ctrl_pkg.sv | 36 +++
 rtl/diffusion_session_ctrl_rb_hold_reg.sv | 40 ++++
 rtl/diffusion_session_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/diffusion_session_ctrl_pkg.sv
// Shared definitions for the diffusion session controller: FSM states,
// table indices and the one-hot BRAM write-enable patterns.
package diffusion_session_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_READ_ADDR,
    ST_READ_HOLD,
    ST_DONE
  } state_t;

  localparam logic [1:0] TBL_S1 = 2'd0;
  localparam logic [1:0] TBL_S2 = 2'd1;
  localparam logic [1:0] TBL_G1 = 2'd2;
  localparam logic [1:0] TBL_G2 = 2'd3;

  localparam logic [3:0] WE_NONE = 4'b0000;
  localparam logic [3:0] WE_S1   = 4'b0001;
  localparam logic [3:0] WE_S2   = 4'b0010;
  localparam logic [3:0] WE_G1   = 4'b0100;
  localparam logic [3:0] WE_G2   = 4'b1000;

  function automatic logic [3:0] tbl_we(input logic [1:0] tbl);
    logic [3:0] we;
    case (tbl)
      TBL_S1:  we = WE_S1;
      TBL_S2:  we = WE_S2;
      TBL_G1:  we = WE_G1;
      default: we = WE_G2;
    endcase
    return we;
  endfunction

endpackage

// File: rtl/diffusion_session_ctrl_rb_hold_reg.sv
// One-entry valid/ready output register for the readback stream; holds the
// word and its last flag stable until the PS accepts it.
module diffusion_session_ctrl_rb_hold_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  rb_valid,
  input  logic                  rb_ready,
  output logic [DATA_WIDTH-1:0] rb_data,
  output logic                  rb_last
);

  logic                  valid_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic                  last_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      last_reg  <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
      data_reg  <= load_data;
      last_reg  <= load_last;
    end else if (valid_reg && rb_ready) begin
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
    end
  end

  assign rb_valid = valid_reg;
  assign rb_data  = data_reg;
  assign rb_last  = last_reg;

endmodule

// File: rtl/diffusion_session_ctrl.sv
// Handshaked session sequencer: loads the four BRAMs from the PS, hands them
// to top_dual for the diffusion run, then streams both score tables back.
module diffusion_session_ctrl
  import diffusion_session_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH     = 13,
  parameter int DEPTH          = 8192,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_RUN_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   cfg_words,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  bram_own,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [3:0]            bram_we,
  output logic [DATA_WIDTH-1:0] bram_wdata,
  input  logic [DATA_WIDTH-1:0] rd_score1,
  input  logic [DATA_WIDTH-1:0] rd_score2,
  output logic                  diff_en,
  input  logic                  diff_done,
  output logic                  rb_valid,
  input  logic                  rb_ready,
  output logic [DATA_WIDTH-1:0] rb_data,
  output logic                  rb_last,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout
);

  localparam int CYC_WIDTH = $clog2(MAX_RUN_CYCLES) + 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   ONE_W    = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ONE_A    = ADDR_WIDTH'(1);
  localparam logic [CYC_WIDTH-1:0]  ONE_C    = CYC_WIDTH'(1);
  localparam logic [CYC_WIDTH-1:0]  CYC_LAST = CYC_WIDTH'(MAX_RUN_CYCLES - 1);

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH:0]     words_reg, words_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [1:0]              tbl_reg, tbl_next;
  logic [CYC_WIDTH-1:0]    cyc_reg, cyc_next;
  logic                    timeout_reg, timeout_next;

  logic                    hold_load;
  logic                    hold_last;
  logic [DATA_WIDTH-1:0]   hold_data;
  logic                    addr_at_end;
  logic [ADDR_WIDTH:0]     clipped_words;

  assign clipped_words = (cfg_words > DEPTH_W) ? DEPTH_W : cfg_words;
  assign addr_at_end   = ({1'b0, addr_reg} == (words_reg - ONE_W));
  // Table index doubles as the score_1/score_2 read select during readback.
  assign hold_data     = (tbl_reg == TBL_S2) ? rd_score2 : rd_score1;

  assign bram_addr = addr_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign timeout   = timeout_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      words_reg   <= '0;
      addr_reg    <= '0;
      tbl_reg     <= TBL_S1;
      cyc_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      words_reg   <= words_next;
      addr_reg    <= addr_next;
      tbl_reg     <= tbl_next;
      cyc_reg     <= cyc_next;
      timeout_reg <= timeout_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    words_next   = words_reg;
    addr_next    = addr_reg;
    tbl_next     = tbl_reg;
    cyc_next     = cyc_reg;
    timeout_next = timeout_reg;
    ld_ready     = 1'b0;
    bram_own     = 1'b1;
    bram_we      = WE_NONE;
    bram_wdata   = '0;
    diff_en      = 1'b0;
    done         = 1'b0;
    hold_load    = 1'b0;
    hold_last    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          words_next   = clipped_words;
          addr_next    = '0;
          tbl_next     = TBL_S1;
          cyc_next     = '0;
          timeout_next = 1'b0;
          state_next   = (clipped_words == '0) ? ST_RUN : ST_LOAD;
        end
      end

      ST_LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          bram_we    = tbl_we(tbl_reg);
          bram_wdata = ld_data;
          if (addr_at_end) begin
            addr_next = '0;
            if (tbl_reg == TBL_G2) begin
              state_next = ST_RUN;
              cyc_next   = '0;
            end else begin
              tbl_next = tbl_reg + 2'd1;
            end
          end else begin
            addr_next = addr_reg + ONE_A;
          end
        end
      end

      ST_RUN: begin
        bram_own = 1'b0;
        diff_en  = 1'b1;
        cyc_next = cyc_reg + ONE_C;
        // A convergence pulse on the watchdog's last cycle still counts as convergence.
        if (diff_done || (cyc_reg == CYC_LAST)) begin
          timeout_next = !diff_done;
          addr_next    = '0;
          tbl_next     = TBL_S1;
          state_next   = (words_reg == '0) ? ST_DONE : ST_READ_ADDR;
        end
      end

      ST_READ_ADDR: begin
        state_next = ST_READ_HOLD;
      end

      ST_READ_HOLD: begin
        if (!rb_valid) begin
          hold_load = 1'b1;
          hold_last = (tbl_reg == TBL_S2) && addr_at_end;
        end else if (rb_ready) begin
          if (rb_last) begin
            state_next = ST_DONE;
          end else if (addr_at_end) begin
            addr_next  = '0;
            tbl_next   = TBL_S2;
            state_next = ST_READ_ADDR;
          end else begin
            addr_next  = addr_reg + ONE_A;
            state_next = ST_READ_ADDR;
          end
        end
      end

      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

  diffusion_session_ctrl_rb_hold_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rb_hold (
    .clk      (clk),
    .rst      (rst),
    .load     (hold_load),
    .load_data(hold_data),
    .load_last(hold_last),
    .rb_valid (rb_valid),
    .rb_ready (rb_ready),
    .rb_data  (rb_data),
    .rb_last  (rb_last)
  );

endmodule
